n64_controller_responder: RTL and testbench

Controller-side Joybus endpoint for the fake N64 build. It decodes console command frames from the single open-drain data line and drives the controller's reply on the same line: identity for 0x00, button/stick state for 0x01. It sits between the pad-side line buffer and the button-state logic. It is the counterpart to the console-side stimulus that drives this line in simulation.

---
 rtl/n64_controller_responder.sv | 217 +++++++++++++++++++++
 tb/tb_n64_controller_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_controller_responder.sv
// Joybus controller endpoint: decodes console commands, drives identity/button replies.
// Define N64_RESET_CMD_EN to answer command 0xFF exactly like 0x00.
module n64_controller_responder #(
  parameter int CLK_PER_US    = 48,
  parameter int RESP_DELAY_US = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_in,
  input  logic [31:0] buttons,
  output logic        data_oe,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic        busy,
  output logic        err
);

  localparam int RESP_CYC = RESP_DELAY_US * CLK_PER_US;
  localparam int IDLE_CYC = 8 * CLK_PER_US;
  localparam int MAX_CYC  =
    (RESP_CYC > IDLE_CYC) ? RESP_CYC : IDLE_CYC;
  localparam int TW = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] T_ONE   = TW'(CLK_PER_US);
  localparam logic [TW-1:0] T_SMP   = TW'(2 * CLK_PER_US);
  localparam logic [TW-1:0] T_ZERO  = TW'(3 * CLK_PER_US);
  localparam logic [TW-1:0] T_BEND  = TW'(4 * CLK_PER_US - 1);
  localparam logic [TW-1:0] T_STOP  = TW'(5 * CLK_PER_US);
  localparam logic [TW-1:0] T_SEND  = TW'(2 * CLK_PER_US - 1);
  localparam logic [TW-1:0] T_IEND  = TW'(IDLE_CYC - 1);
  localparam logic [TW-1:0] T_REND  = TW'(RESP_CYC - 1);
  localparam logic [23:0]   INFO_ID = 24'h050002;

  typedef enum logic [2:0] {
    IDLE,
    RX_BIT,
    RESP_WAIT,
    TX_BIT,
    TX_STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_d;
  logic          sync1, sync2, sync_q;
  logic          fall;
  logic [TW-1:0] timer, timer_d;
  logic [8:0]    rx_sr, rx_sr_d;
  logic [5:0]    rx_cnt, rx_cnt_d;
  logic [31:0]   tx_sr, tx_sr_d;
  logic [5:0]    tx_cnt, tx_cnt_d;
  logic [7:0]    cmd_q;
  logic [7:0]    rx_byte;
  logic          oe_d;
  logic          is_info;
  logic          start_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync1  <= data_in;
      sync2  <= sync1;
      sync_q <= sync2;
    end
  end

  assign fall    = sync_q & ~sync2;
  assign rx_byte = rx_sr[8:1];
  assign cmd     = cmd_valid ? rx_byte : cmd_q;
  assign busy    = (state != IDLE) | fall;

  always_comb begin
    is_info = (rx_byte == 8'h00);
`ifdef N64_RESET_CMD_EN
    is_info = is_info | (rx_byte == 8'hFF);
`else
    is_info = is_info & 1'b1;
`endif
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    rx_sr_d   = rx_sr;
    rx_cnt_d  = rx_cnt;
    tx_sr_d   = tx_sr;
    tx_cnt_d  = tx_cnt;
    cmd_valid = 1'b0;
    err       = 1'b0;
    start_tx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_d  = RX_BIT;
          timer_d  = TW'(1);
          rx_cnt_d = '0;
        end
      end
      RX_BIT: begin
        timer_d = timer + TW'(1);
        // An edge beats a coincident stop timeout.
        if (fall) begin
          if (timer <= T_SMP || rx_cnt >= 6'd9) begin
            err     = 1'b1;
            state_d = WAIT_IDLE;
            timer_d = '0;
          end else begin
            timer_d = TW'(1);
          end
        end else if (timer == T_SMP) begin
          rx_sr_d  = {rx_sr[7:0], sync2};
          rx_cnt_d = rx_cnt + 6'd1;
        end else if (timer == T_STOP) begin
          state_d = IDLE;
          if (rx_cnt == 6'd9 && rx_sr[0]) begin
            cmd_valid = 1'b1;
            unique case (1'b1)
              is_info: begin
                tx_sr_d  = {INFO_ID, 8'h00};
                tx_cnt_d = 6'd24;
                start_tx = 1'b1;
              end
              rx_byte == 8'h01: begin
                tx_sr_d  = buttons;
                tx_cnt_d = 6'd32;
                start_tx = 1'b1;
              end
              default: err = 1'b1;
            endcase
          end else begin
            err = 1'b1;
          end
        end
      end
      RESP_WAIT: begin
        timer_d = timer + TW'(1);
        if (timer == T_REND) begin
          state_d = TX_BIT;
          timer_d = '0;
        end
      end
      TX_BIT: begin
        timer_d = timer + TW'(1);
        if (timer == T_BEND) begin
          timer_d  = '0;
          tx_sr_d  = {tx_sr[30:0], 1'b0};
          tx_cnt_d = tx_cnt - 6'd1;
          if (tx_cnt == 6'd1) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        timer_d = timer + TW'(1);
        if (timer == T_SEND) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      WAIT_IDLE: begin
        if (!sync2) begin
          timer_d = '0;
        end else if (timer == T_IEND) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A one-cycle delay means the reply starts straight from the accept.
    if (start_tx) begin
      if (RESP_CYC <= 1) begin
        state_d = TX_BIT;
        timer_d = '0;
      end else begin
        state_d = RESP_WAIT;
        timer_d = TW'(1);
      end
    end
  end

  always_comb begin
    oe_d = 1'b0;
    unique case (1'b1)
      state_d == TX_BIT:
        oe_d = timer_d < (tx_sr_d[31] ? T_ONE : T_ZERO);
      state_d == TX_STOP:
        oe_d = timer_d < T_SMP;
      default: oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      rx_sr   <= '0;
      rx_cnt  <= '0;
      tx_sr   <= '0;
      tx_cnt  <= '0;
      cmd_q   <= '0;
      data_oe <= 1'b0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      rx_sr   <= rx_sr_d;
      rx_cnt  <= rx_cnt_d;
      tx_sr   <= tx_sr_d;
      tx_cnt  <= tx_cnt_d;
      data_oe <= oe_d;
      if (cmd_valid) cmd_q <= rx_byte;
    end
  end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Directed Joybus frames; reply pulses checked against a queue of expected widths.
// Build with N64_RESET_CMD_EN defined to expect 0xFF answered like 0x00.
module tb_n64_controller_responder;

  localparam int C = 4;
  localparam int D = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        con_low = 1'b0;
  logic [31:0] buttons = '0;
  logic        data_in;
  logic        data_oe;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cv_cnt = 0;
  int err_cnt = 0;
  int pulse_cnt = 0;
  int err_cyc = 0;
  int run = 0;
  int last_rel = 0;
  int f10, f5, e0, c0, p0;
  bit mon_en = 1'b1;
  int exp_q[$];
  logic [7:0] got_cmd;
  logic       got_err;
  logic [4:0] trunc_bits;

  assign data_in = ~(con_low | data_oe);

  n64_controller_responder #(
    .CLK_PER_US   (C),
    .RESP_DELAY_US(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .buttons  (buttons),
    .data_oe  (data_oe),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (cmd_valid) cv_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (data_oe) begin
        run++;
      end else if (run != 0) begin
        pulse_cnt++;
        if (mon_en) begin
          if (exp_q.size() == 0)
            check("unexpected pulse", run, 0);
          else
            check("pulse width", run, exp_q.pop_front());
        end
        run = 0;
      end
    end
  end

  task automatic send_bit(input logic b);
    con_low = 1'b1;
    repeat (b ? C : 3 * C) @(negedge clk);
    con_low = 1'b0;
    last_rel = cyc;
    repeat (b ? 3 * C : C) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    send_bit(1'b1);
  endtask

  task automatic expect_reply(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--)
      exp_q.push_back(v[i] ? C : 3 * C);
    exp_q.push_back(2 * C);
  endtask

  task automatic wait_cv(input string tag,
                         output logic [7:0] c,
                         output logic e);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (cmd_valid) ok = 1'b1;
      else @(negedge clk);
    end
    c = cmd;
    e = err;
    check({tag, " cmd_valid"}, 32'(ok), 1);
  endtask

  task automatic reply_timing(input string tag, input int n);
    int k;
    k = 0;
    while (!data_oe && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) buttons = ~buttons;
    end
    check({tag, " first rise"}, k, D * C);
    while (busy && k < 800) begin
      @(negedge clk);
      k++;
    end
    check({tag, " duration"}, k, D * C + 4 * C * n + 2 * C);
    @(negedge clk);
    check({tag, " drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst data_oe", data_oe, 0);
    check("rst cmd_valid", cmd_valid, 0);
    check("rst cmd", cmd, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle busy", busy, 0);
    check("idle data_oe", data_oe, 0);

    // Poll
    buttons = 32'h8000_00FF;
    expect_reply(buttons, 32);
    send_cmd(8'h01);
    wait_cv("poll", got_cmd, got_err);
    check("poll cmd", got_cmd, 8'h01);
    check("poll err", got_err, 0);
    reply_timing("poll", 32);
    check("poll cmd held", cmd, 8'h01);

    // Info
    expect_reply(32'h0005_0002, 24);
    send_cmd(8'h00);
    wait_cv("info", got_cmd, got_err);
    check("info cmd", got_cmd, 8'h00);
    reply_timing("info", 24);

    // Unsupported multi-byte
    e0 = err_cnt;
    c0 = cv_cnt;
    p0 = pulse_cnt;
    send_cmd(8'h02);
    f10 = cyc;
    send_cmd(8'h00);
    while (cyc < last_rel + 33) @(negedge clk);
    check("multi busy before", busy, 1);
    @(negedge clk);
    check("multi busy after", busy, 0);
    check("multi err cnt", err_cnt - e0, 1);
    check("multi err time", err_cyc - f10, 2);
    check("multi no cmd_valid", cv_cnt - c0, 0);
    check("multi no drive", pulse_cnt - p0, 0);
    buttons = 32'h0F0F_A5C3;
    expect_reply(buttons, 32);
    send_cmd(8'h01);
    wait_cv("repoll", got_cmd, got_err);
    check("repoll cmd", got_cmd, 8'h01);
    reply_timing("repoll", 32);

    // Truncated frame
    e0 = err_cnt;
    c0 = cv_cnt;
    p0 = pulse_cnt;
    trunc_bits = 5'b10100;
    for (int i = 4; i >= 0; i--) begin
      if (i == 0) f5 = cyc;
      send_bit(trunc_bits[i]);
    end
    repeat (40) @(negedge clk);
    check("trunc err cnt", err_cnt - e0, 1);
    check("trunc err time", err_cyc - f5, 2 + 5 * C);
    check("trunc no cmd_valid", cv_cnt - c0, 0);
    check("trunc no drive", pulse_cnt - p0, 0);

    // Reset during reply bit 10
    buttons = 32'h8000_00FF;
    expect_reply(buttons, 32);
    send_cmd(8'h01);
    wait_cv("rstpoll", got_cmd, got_err);
    repeat (D * C + 9 * 4 * C + 2) @(negedge clk);
    check("pre-reset data_oe", data_oe, 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset data_oe", data_oe, 0);
    check("async reset busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    check("post-reset cmd", cmd, 0);
    expect_reply(32'h0005_0002, 24);
    send_cmd(8'h00);
    wait_cv("postrst", got_cmd, got_err);
    check("postrst cmd", got_cmd, 8'h00);
    reply_timing("postrst", 24);

    // Command 0xFF
    p0 = pulse_cnt;
`ifdef N64_RESET_CMD_EN
    expect_reply(32'h0005_0002, 24);
    send_cmd(8'hFF);
    wait_cv("ff", got_cmd, got_err);
    check("ff cmd", got_cmd, 8'hFF);
    check("ff err", got_err, 0);
    reply_timing("ff", 24);
`else
    send_cmd(8'hFF);
    wait_cv("ff", got_cmd, got_err);
    check("ff cmd", got_cmd, 8'hFF);
    check("ff err", got_err, 1);
    repeat (60) @(negedge clk);
    check("ff no drive", pulse_cnt - p0, 0);
    check("ff busy", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
